// File: rtl/prng_pkg.sv
// ---------------------------------------------------------------------------
// prng_pkg
// Shared definitions for the PRNG display path:
//   disp_state_t : display sequencer states (IDLE, SHOW_HI, SHOW_LO)
//   HEX_SEG7     : hex digit -> active-high segment code, bit 0 = a .. bit 6 = g
//   SEG_BLANK    : all segments off
// ---------------------------------------------------------------------------
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_HI = 2'd1,
        SHOW_LO = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index 0 is digit 0. Lower-case b and d keep them distinct from 8 and 0.
    localparam logic [6:0] HEX_SEG7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage : prng_pkg

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational hex-digit to seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : active-high segment code, seg[0] = a .. seg[6] = g
// ---------------------------------------------------------------------------
module hex_to_seg7
    import prng_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG7[nibble];

endmodule : hex_to_seg7

// File: rtl/prng_seg_display.sv
// ---------------------------------------------------------------------------
// prng_seg_display
// Takes one random byte at a time over valid/ready and shows it as two hex
// digits (high nibble with dp lit, then low nibble), each held TICK_CYCLES
// clocks. Back-pressures the source while a byte is on display.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   rnd_data  : byte from the PRNG
//   rnd_valid : rnd_data valid
//   rnd_ready : byte accepted on this edge when rnd_valid is also high
//   freeze    : holds digit, timer and outputs; forces rnd_ready low
//   seg       : registered segment drive, active-high
//   dp        : registered, 1 while the high nibble is shown
//   busy      : registered, 1 while a byte is on display
// ---------------------------------------------------------------------------
module prng_seg_display
    import prng_pkg::*;
#(
    parameter int CLK_HZ  = 10_000_000,
    parameter int SHOW_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rnd_data,
    input  logic       rnd_valid,
    output logic       rnd_ready,
    input  logic       freeze,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int TICK_CYCLES = CLK_HZ / SHOW_HZ;
    localparam int CNT_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    if (TICK_CYCLES < 2) begin : g_bad_tick
        $error("prng_seg_display: CLK_HZ / SHOW_HZ must be at least 2");
    end

    disp_state_t      state, state_next;
    logic [7:0]       byte_q, byte_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             tick_end;
    logic             transfer;
    logic [3:0]       nibble_next;
    logic [6:0]       digit_seg;
    logic [6:0]       seg_next;

    // Ready comes only from registered state, freeze and reset, never from
    // rnd_valid, so the source may legally wait for ready before raising valid.
    assign tick_end  = (cnt == CNT_LAST) && !freeze;
    assign rnd_ready = !rst && !freeze &&
                       ((state == IDLE) || ((state == SHOW_LO) && (cnt == CNT_LAST)));
    assign transfer  = rnd_valid && rnd_ready;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        state_next = state;
        byte_next  = byte_q;

        unique case (state)
            IDLE: begin
                if (transfer) begin
                    state_next = SHOW_HI;
                    byte_next  = rnd_data;
                end
            end
            SHOW_HI: begin
                if (tick_end) state_next = SHOW_LO;
            end
            SHOW_LO: begin
                if (tick_end) begin
                    if (transfer) begin
                        state_next = SHOW_HI;
                        byte_next  = rnd_data;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Every state change enters a fresh digit, so the timer restarts there.
    always_comb begin
        cnt_next = cnt;
        if (state_next != state) begin
            cnt_next = '0;
        end else if ((state != IDLE) && !freeze) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Decode the digit the next state will show, so seg/dp update on the same
    // edge as the state register.
    assign nibble_next = (state_next == SHOW_HI) ? byte_next[7:4] : byte_next[3:0];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_next),
        .seg    (digit_seg)
    );

    assign seg_next = (state_next == IDLE) ? SEG_BLANK : digit_seg;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            byte_q <= 8'h00;
            cnt    <= '0;
            seg    <= SEG_BLANK;
            dp     <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            byte_q <= byte_next;
            cnt    <= cnt_next;
            seg    <= seg_next;
            dp     <= (state_next == SHOW_HI);
            busy   <= (state_next != IDLE);
        end
    end

endmodule : prng_seg_display
